iir_ctrl: RTL and testbench

IIR_CTRL -- requirements
Module: iir_ctrl

---
 rtl/iir_ctrl.sv | 153 +++++++++++++++
 tb/tb_iir_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_ctrl.sv
// iir_ctrl: first-order IIR controller, y = b*x + ab*x1 + a2b*x2 + a*y1, one shared MAC.
// Optional output clamping enabled by defining IIR_CTRL_SAT_EN.
module iir_ctrl #(
    parameter int COEF_A = -1,
    parameter int COEF_B = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [7:0]  data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] data_out,
    output logic               busy
);

    localparam logic signed [7:0]  A   = 8'(COEF_A);
    localparam logic signed [7:0]  B   = 8'(COEF_B);
    localparam logic signed [15:0] AB  = 16'(COEF_A * COEF_B);
    localparam logic signed [23:0] A2B = 24'(COEF_A * COEF_A * COEF_B);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_cnt;
    logic signed [31:0] r_acc;
    logic signed [7:0]  r_x;
    logic signed [7:0]  r_x1;
    logic signed [7:0]  r_x2;
    logic signed [15:0] r_y1;
    logic signed [15:0] r_dout;
    logic               r_ovld;

    logic signed [31:0] w_coef;
    logic signed [31:0] w_opnd;
    logic signed [31:0] w_prod;
    logic signed [15:0] w_red;
    logic               w_accept;
    logic               w_out_hs;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign w_out_hs  = r_ovld && out_ready;
    assign out_valid = r_ovld;
    assign data_out  = r_dout;

    // Term select: the counter walks b*x, ab*x1, a2b*x2, a*y1.
    always_comb begin
        w_coef = '0;
        w_opnd = '0;
        unique case (r_cnt)
            2'd0: begin
                w_coef = {{24{B[7]}}, B};
                w_opnd = {{24{r_x[7]}}, r_x};
            end
            2'd1: begin
                w_coef = {{16{AB[15]}}, AB};
                w_opnd = {{24{r_x1[7]}}, r_x1};
            end
            2'd2: begin
                w_coef = {{8{A2B[23]}}, A2B};
                w_opnd = {{24{r_x2[7]}}, r_x2};
            end
            2'd3: begin
                w_coef = {{24{A[7]}}, A};
                w_opnd = {{16{r_y1[15]}}, r_y1};
            end
        endcase
    end

    assign w_prod = w_coef * w_opnd;

`ifdef IIR_CTRL_SAT_EN
    always_comb begin
        if (r_acc > 32'sd32767)
            w_red = 16'sh7fff;
        else if (r_acc < -32'sd32768)
            w_red = 16'sh8000;
        else
            w_red = 16'(r_acc);
    end
`else
    assign w_red = 16'(r_acc);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_MAC;
            S_MAC:   if (r_cnt == 2'd3) w_next = S_OUT;
            S_OUT:   if (w_out_hs) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == S_IDLE);
        busy     = (r_state != S_IDLE);
    end

    // OUT spends one cycle registering the reduced result before presenting it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_x    <= '0;
            r_x1   <= '0;
            r_x2   <= '0;
            r_y1   <= '0;
            r_dout <= '0;
            r_ovld <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x   <= data_in;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_prod;
                    r_cnt <= r_cnt + 2'd1;
                end
                S_OUT: begin
                    if (!r_ovld) begin
                        r_dout <= w_red;
                        r_ovld <= 1'b1;
                    end else if (out_ready) begin
                        r_ovld <= 1'b0;
                        r_x2   <= r_x1;
                        r_x1   <= r_x;
                        r_y1   <= r_dout;
                    end
                end
                default: r_ovld <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_ctrl.sv
// tb_iir_ctrl: directed and random checks of iir_ctrl against an arithmetic model.
// Expectations for the clamped build follow IIR_CTRL_SAT_EN.
module tb_iir_ctrl;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  data_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] data_out;
    logic               busy;

    logic               s_in_valid;
    logic               s_in_ready;
    logic signed [7:0]  s_data_in;
    logic               s_out_valid;
    logic               s_out_ready;
    logic signed [15:0] s_data_out;
    logic               s_busy;

    int checks = 0;
    int errors = 0;

    longint m_x1, m_x2, m_y1;

    iir_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    iir_ctrl #(.COEF_A(127), .COEF_B(127)) u_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .data_in   (s_data_in),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .data_out  (s_data_out),
        .busy      (s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint reduce16(input longint v);
`ifdef IIR_CTRL_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        return ((v + 32768) % 65536 + 65536) % 65536 - 32768;
`endif
    endfunction

    function automatic longint ref_y(input longint a, input longint b,
                                     input longint x, input longint x1,
                                     input longint x2, input longint y1);
        return reduce16(b * x + a * b * x1 + a * a * b * x2 + a * y1);
    endfunction

    task automatic clear_model();
        m_x1 = 0;
        m_x2 = 0;
        m_y1 = 0;
    endtask

    task automatic run_sample(input logic signed [7:0] x, input int hold,
                              input bit noise, output logic signed [15:0] got);
        int     lat;
        longint expv;
        expv = ref_y(-1, 4, x, m_x1, m_x2, m_y1);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        data_in  = x;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = 8'($urandom);
        chk("busy_mac", busy, 1);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (noise) begin
                in_valid = 1'($urandom);
                data_in  = 8'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 5);
        got = data_out;
        for (int h = 0; h < hold; h++) begin
            if (noise) begin
                in_valid = 1'($urandom);
                data_in  = 8'($urandom);
            end
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_data", data_out, got);
            chk("hold_in_ready", in_ready, 0);
        end
        chk("data", data_out, expv);
        out_ready = 1'b1;
        if (noise) begin
            in_valid = 1'b1;
            data_in  = 8'($urandom);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
        m_x2 = m_x1;
        m_x1 = x;
        m_y1 = expv;
    endtask

    task automatic sat_sample(input logic signed [7:0] x, input longint exp,
                              input string tag);
        int lat;
        @(negedge clk);
        s_in_valid = 1'b1;
        s_data_in  = x;
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        lat = 0;
        while (s_out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 5);
        chk(tag, s_data_out, exp);
        s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        s_out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
    endtask

    logic signed [15:0] got;
    longint             imp_exp [4];

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        data_in     = '0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_data_in   = '0;
        s_out_ready = 1'b0;
        imp_exp[0] = 4;
        imp_exp[1] = -8;
        imp_exp[2] = 12;
        imp_exp[3] = -12;
        clear_model();

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_sample((i == 0) ? 8'sd1 : 8'sd0, 0, 1'b0, got);
            chk("impulse", got, imp_exp[i]);
        end

        run_sample(8'($urandom), 3, 1'b0, got);
        for (int i = 0; i < 10; i++)
            run_sample(8'($urandom), int'($urandom_range(0, 3)),
                       1'($urandom), got);

        @(negedge clk);
        in_valid = 1'b1;
        data_in  = 8'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_data_out", data_out, 0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        run_sample(8'sd1, 0, 1'b0, got);
        chk("post_rst_impulse", got, 4);

        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            run_sample((i == 0) ? 8'sd1 : 8'sd0, int'($urandom_range(0, 2)),
                       1'b1, got);
            chk("noise_impulse", got, imp_exp[i]);
        end

        pulse_reset();
        sat_sample(8'sd127, 16129, "sat_first");
`ifdef IIR_CTRL_SAT_EN
        sat_sample(8'sd0, 32767, "sat_second");
`else
        sat_sample(8'sd0, -32002, "sat_second");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
